// File: rtl/lsu_mem_stage_if.sv
// Data-memory port bundle for the LSU: request channel with valid/ready and
// a response channel carrying read data or a write acknowledge.
interface lsu_mem_stage_if #(
    parameter int N_BITS = 32
);
    logic              dmem_req_vld;
    logic              dmem_req_rdy;
    logic [N_BITS-1:0] dmem_addr;
    logic              dmem_we;
    logic [3:0]        dmem_wstrb;
    logic [N_BITS-1:0] dmem_wdata;
    logic              dmem_rsp_vld;
    logic [N_BITS-1:0] dmem_rdata;

    modport master (
        output dmem_req_vld,
        input  dmem_req_rdy,
        output dmem_addr,
        output dmem_we,
        output dmem_wstrb,
        output dmem_wdata,
        input  dmem_rsp_vld,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req_vld,
        output dmem_req_rdy,
        input  dmem_addr,
        input  dmem_we,
        input  dmem_wstrb,
        input  dmem_wdata,
        output dmem_rsp_vld,
        output dmem_rdata
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: one outstanding access at a time, store lane
// alignment, load extraction/extension, and a single-cycle writeback beat.
module lsu_mem_stage #(
    parameter int N_BITS       = 32,
    parameter int RF_IDX_WIDTH = 5,
    parameter int TIMEOUT      = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ex_vld,
    output logic                    ex_rdy,
    input  logic                    ex_mtype,
    input  logic [1:0]              ex_len,
    input  logic                    ex_unsigned,
    input  logic [N_BITS-1:0]       ex_addr,
    input  logic [N_BITS-1:0]       ex_wdata,
    input  logic [RF_IDX_WIDTH-1:0] ex_rd,
    input  logic                    ex_wr_en,
    lsu_mem_stage_if.master         dmem,
    output logic                    wb_vld,
    output logic [RF_IDX_WIDTH-1:0] wb_rd,
    output logic                    wb_wr_en,
    output logic [N_BITS-1:0]       wb_data,
    output logic                    exc_misalign,
    output logic                    exc_timeout
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t state_reg, state_next;
    logic [7:0] cnt_reg, cnt_next;

    logic                    mtype_reg;
    logic [1:0]              len_reg;
    logic                    unsigned_reg;
    logic [N_BITS-1:0]       addr_reg;
    logic [N_BITS-1:0]       wdata_reg;
    logic [RF_IDX_WIDTH-1:0] rd_reg;
    logic                    wr_en_reg;
    logic                    misalign_reg;
    logic                    timeout_reg;
    logic [N_BITS-1:0]       data_reg;

    logic                    misalign_in;
    logic                    req_vld;
    logic                    rsp_take;
    logic                    timeout_hit;
    logic [3:0]              wstrb_lane;
    logic [N_BITS-1:0]       wdata_lane;
    logic [N_BITS-1:0]       rdata_shift;
    logic [N_BITS-1:0]       load_ext;

    // Reserved length is folded into the misalign exception so it never reaches the bus.
    assign misalign_in = (ex_len == 2'b11)
                       | ((ex_len == 2'b01) & ex_addr[0])
                       | ((ex_len == 2'b10) & (ex_addr[1:0] != 2'b00));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 8'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        ex_rdy      = 1'b0;
        req_vld     = 1'b0;
        rsp_take    = 1'b0;
        timeout_hit = 1'b0;
        case (state_reg)
            IDLE: begin
                ex_rdy   = 1'b1;
                cnt_next = 8'd0;
                if (ex_vld) begin
                    state_next = misalign_in ? DONE : SEND;
                end
            end
            SEND: begin
                req_vld = 1'b1;
                if (dmem.dmem_req_rdy) begin
                    state_next = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                // A response arriving on the limit cycle still completes normally.
                if (dmem.dmem_rsp_vld) begin
                    rsp_take   = 1'b1;
                    state_next = DONE;
                end else if (cnt_reg == TIMEOUT_CNT) begin
                    timeout_hit = 1'b1;
                    state_next  = DONE;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            DONE: begin
                cnt_next   = 8'd0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mtype_reg    <= 1'b0;
            len_reg      <= 2'b00;
            unsigned_reg <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            rd_reg       <= '0;
            wr_en_reg    <= 1'b0;
            misalign_reg <= 1'b0;
            timeout_reg  <= 1'b0;
            data_reg     <= '0;
        end else begin
            if (ex_rdy && ex_vld) begin
                mtype_reg    <= ex_mtype;
                len_reg      <= ex_len;
                unsigned_reg <= ex_unsigned;
                addr_reg     <= ex_addr;
                wdata_reg    <= ex_wdata;
                rd_reg       <= ex_rd;
                wr_en_reg    <= ex_wr_en;
                misalign_reg <= misalign_in;
                timeout_reg  <= 1'b0;
                data_reg     <= '0;
            end
            if (rsp_take && !mtype_reg) begin
                data_reg <= load_ext;
            end
            if (timeout_hit) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    // Per-lane strobe and write data; a half store lands in lanes {1,0} or {3,2}.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign wstrb_lane[gi] = (len_reg == 2'b00) ? (addr_reg[1:0] == 2'(gi)) :
                                (len_reg == 2'b01) ? (addr_reg[1] == 1'(gi / 2)) :
                                                     1'b1;
        assign wdata_lane[8*gi +: 8] = (len_reg == 2'b00) ? wdata_reg[7:0] :
                                       (len_reg == 2'b01) ? wdata_reg[8*(gi % 2) +: 8] :
                                                            wdata_reg[8*gi +: 8];
    end

    assign rdata_shift = dmem.dmem_rdata >> {addr_reg[1:0], 3'b000};

    always_comb begin
        case (len_reg)
            2'b00:   load_ext = unsigned_reg ? {{(N_BITS-8){1'b0}}, rdata_shift[7:0]}
                                             : {{(N_BITS-8){rdata_shift[7]}}, rdata_shift[7:0]};
            2'b01:   load_ext = unsigned_reg ? {{(N_BITS-16){1'b0}}, rdata_shift[15:0]}
                                             : {{(N_BITS-16){rdata_shift[15]}}, rdata_shift[15:0]};
            default: load_ext = rdata_shift;
        endcase
    end

    // Bus fields are forced to zero outside SEND so idle outputs stay quiet.
    assign dmem.dmem_req_vld = req_vld;
    assign dmem.dmem_addr    = req_vld ? {addr_reg[N_BITS-1:2], 2'b00} : '0;
    assign dmem.dmem_we      = req_vld & mtype_reg;
    assign dmem.dmem_wstrb   = req_vld ? wstrb_lane : 4'b0000;
    assign dmem.dmem_wdata   = req_vld ? wdata_lane : '0;

    assign wb_vld       = (state_reg == DONE);
    assign wb_rd        = wb_vld ? rd_reg : '0;
    assign wb_data      = wb_vld ? data_reg : '0;
    assign exc_misalign = wb_vld & misalign_reg;
    assign exc_timeout  = wb_vld & timeout_reg;
    assign wb_wr_en     = wb_vld & ~mtype_reg & wr_en_reg & (rd_reg != '0)
                        & ~misalign_reg & ~timeout_reg;

endmodule
